act_grad_unit: RTL and testbench

Backward-pass companion to the forward activation out = (|X+1| + |X−1|) >> 1, which equals max(|X|, 1).
- Forward side: captures the slope class of each 2·WIDTH-bit pre-activation in an in-order queue.
- Backward side: multiplies each arriving WIDTH-bit error term by the stored local derivative (+1, −1 or 0).
- Sits between the forward activation stage and the layer's backward error path.
- Uses valid/ready handshakes on all three streams.

---
 rtl/act_grad_unit_if.sv | 36 +++
 rtl/act_grad_unit.sv | 146 ++++++++++++++
 tb/tb_act_grad_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_grad_unit_if.sv
// rtl/act_grad_unit_if.sv - stream bundle for the activation-gradient unit
//
// Purpose: groups the forward (pre-activation), backward (error term) and
// gradient streams plus the queue level into one bundle.
// master : the surrounding datapath (drives fwd/bwd data, accepts gradients)
// slave  : act_grad_unit
// Signals: fwd_valid/fwd_ready/fwd_x, bwd_valid/bwd_ready/bwd_delta,
//          grad_valid/grad_ready/grad_out/grad_mask, level.
interface act_grad_unit_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                        fwd_valid;
  logic                        fwd_ready;
  logic signed [2*WIDTH-1:0]   fwd_x;
  logic                        bwd_valid;
  logic                        bwd_ready;
  logic signed [WIDTH-1:0]     bwd_delta;
  logic                        grad_valid;
  logic                        grad_ready;
  logic signed [WIDTH-1:0]     grad_out;
  logic                        grad_mask;
  logic [LW-1:0]               level;

  modport master (
    output fwd_valid, fwd_x, bwd_valid, bwd_delta, grad_ready,
    input  fwd_ready, bwd_ready, grad_valid, grad_out, grad_mask, level
  );

  modport slave (
    input  fwd_valid, fwd_x, bwd_valid, bwd_delta, grad_ready,
    output fwd_ready, bwd_ready, grad_valid, grad_out, grad_mask, level
  );
endinterface

// File: rtl/act_grad_unit.sv
// rtl/act_grad_unit.sv - backward-pass derivative unit for out = max(|x|, 1)
//
// Purpose: records the slope class (POS / NEG / ZERO) of each forward
// pre-activation in an in-order queue, then multiplies each backward error
// term by the matching stored derivative (+1, -1, 0) into a registered
// gradient output.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (flushes queue, drops gradient)
//   bus  - act_grad_unit_if.slave: fwd stream (push), bwd stream (pop),
//          grad stream (registered output), level (entries queued)
// Optional feature macro: ACT_GRAD_SAT_EN
//   defined   - negating the most negative error term saturates to max
//   undefined - negation wraps in two's complement
module act_grad_unit #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  act_grad_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] SLOPE_ZERO = 2'b00;
  localparam logic [1:0] SLOPE_POS  = 2'b01;
  localparam logic [1:0] SLOPE_NEG  = 2'b10;

  // |x+1|+|x-1| is flat on [-1, 1], so only |x| >= 2 carries a slope.
  localparam logic signed [2*WIDTH-1:0] X_POS_MIN = (2*WIDTH)'(2);
  localparam logic signed [2*WIDTH-1:0] X_NEG_MAX = -X_POS_MIN;

  logic [1:0]              r_mem [DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [LW-1:0]           r_level;
  logic                    r_grad_valid;
  logic signed [WIDTH-1:0] r_grad_out;
  logic                    r_grad_mask;

  logic signed [2*WIDTH-1:0] w_x;
  logic [1:0]                w_code;
  logic [1:0]                w_rd_code;
  logic                      w_full;
  logic                      w_fwd_ready;
  logic                      w_bwd_ready;
  logic                      w_push;
  logic                      w_pop;
  logic signed [WIDTH-1:0]   w_delta;
  logic signed [WIDTH-1:0]   w_neg;
  logic signed [WIDTH-1:0]   w_neg_fix;
  logic signed [WIDTH-1:0]   w_grad;

  assign w_x = bus.fwd_x;

  always_comb begin
    w_code = SLOPE_ZERO;
    if (w_x >= X_POS_MIN) begin
      w_code = SLOPE_POS;
    end else if (w_x <= X_NEG_MAX) begin
      w_code = SLOPE_NEG;
    end
  end

  // A concurrent pop never frees space for a push in the same cycle when
  // full; this keeps fwd_ready independent of the backward stream.
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_fwd_ready = !rst && !w_full;
  assign w_bwd_ready = !rst && (r_level != '0) && (!r_grad_valid || bus.grad_ready);
  assign w_push      = bus.fwd_valid && w_fwd_ready;
  assign w_pop       = bus.bwd_valid && w_bwd_ready;

  assign w_rd_code = r_mem[r_rptr];
  assign w_delta   = bus.bwd_delta;
  assign w_neg     = -w_delta;

`ifdef ACT_GRAD_SAT_EN
  localparam logic signed [WIDTH-1:0] D_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] D_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  assign w_neg_fix = (w_delta == D_MIN) ? D_MAX : w_neg;
`else
  assign w_neg_fix = w_neg;
`endif

  always_comb begin
    w_grad = '0;
    case (w_rd_code)
      SLOPE_POS: w_grad = w_delta;
      SLOPE_NEG: w_grad = w_neg_fix;
      default:   w_grad = '0;
    endcase
  end

  // Slope storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Output register: load on pop, hold under backpressure, drop valid once
  // consumed with nothing new behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grad_valid <= 1'b0;
      r_grad_out   <= '0;
      r_grad_mask  <= 1'b0;
    end else if (w_pop) begin
      r_grad_valid <= 1'b1;
      r_grad_out   <= w_grad;
      r_grad_mask  <= (w_rd_code != SLOPE_ZERO);
    end else if (bus.grad_ready) begin
      r_grad_valid <= 1'b0;
    end
  end

  assign bus.fwd_ready  = w_fwd_ready;
  assign bus.bwd_ready  = w_bwd_ready;
  assign bus.grad_valid = r_grad_valid;
  assign bus.grad_out   = r_grad_out;
  assign bus.grad_mask  = r_grad_mask;
  assign bus.level      = r_level;

endmodule

// File: tb/tb_act_grad_unit.sv
// tb/tb_act_grad_unit.sv - self-checking bench for act_grad_unit
module tb_act_grad_unit;
  localparam int W = 9;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  act_grad_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();
  act_grad_unit #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  // Reference model: queue of raw pre-activations plus expected output reg.
  logic signed [2*W-1:0] q[$];
  logic                  e_gv;
  logic signed [W-1:0]   e_go;
  logic                  e_gm;
  logic                  e_fr, e_br;
  logic                  o_fr, o_br;

  function automatic logic signed [W-1:0] ref_grad(input logic signed [2*W-1:0] x,
                                                  input logic signed [W-1:0] d);
    int xv, dv, r;
    xv = x;
    dv = d;
    if (xv >= 2) r = dv;
    else if (xv <= -2) r = -dv;
    else r = 0;
`ifdef ACT_GRAD_SAT_EN
    if (r > 255) r = 255;
`endif
    return r[W-1:0];
  endfunction

  function automatic logic ref_mask(input logic signed [2*W-1:0] x);
    int xv;
    xv = x;
    return (xv >= 2) || (xv <= -2);
  endfunction

  task automatic model_reset();
    q.delete();
    e_gv = 1'b0;
    e_go = '0;
    e_gm = 1'b0;
  endtask

  // One clock of stimulus; records observed readies and advances the model.
  task automatic step(input logic fv, input logic signed [2*W-1:0] fx,
                      input logic bv, input logic signed [W-1:0] bd,
                      input logic gr);
    logic signed [2*W-1:0] x;
    bus.fwd_valid  = fv;
    bus.fwd_x      = fx;
    bus.bwd_valid  = bv;
    bus.bwd_delta  = bd;
    bus.grad_ready = gr;
    @(negedge clk);
    o_fr = bus.fwd_ready;
    o_br = bus.bwd_ready;
    e_fr = (q.size() < D);
    e_br = (q.size() != 0) && (!e_gv || gr);
    if (bv && e_br) begin
      x = q.pop_front();
      e_gv = 1'b1;
      e_go = ref_grad(x, bd);
      e_gm = ref_mask(x);
    end else if (gr) begin
      e_gv = 1'b0;
    end
    if (fv && e_fr) q.push_back(fx);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fwd_valid  = 1'b0;
    bus.fwd_x      = '0;
    bus.bwd_valid  = 1'b0;
    bus.bwd_delta  = '0;
    bus.grad_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic signed [2*W-1:0] rand_x();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 2) == 0) return 18'($signed($urandom_range(0, 6)) - 3);
    return r[2*W-1:0];
  endfunction

  function automatic logic signed [W-1:0] rand_d();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return 9'h100;
    return r[W-1:0];
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.fwd_ready !== 1'b0) $display("FAIL rst_fwd_ready got %b want 0", bus.fwd_ready); else n_pass++;
    n_total++; if (bus.bwd_ready !== 1'b0) $display("FAIL rst_bwd_ready got %b want 0", bus.bwd_ready); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (bus.level !== 5'd0) $display("FAIL rst_level got %0d want 0", bus.level); else n_pass++;
    n_total++; if (bus.grad_valid !== 1'b0) $display("FAIL rst_grad_valid got %b want 0", bus.grad_valid); else n_pass++;
    n_total++; if (bus.grad_out !== 9'd0) $display("FAIL rst_grad_out got %0d want 0", bus.grad_out); else n_pass++;
    n_total++; if (bus.grad_mask !== 1'b0) $display("FAIL rst_grad_mask got %b want 0", bus.grad_mask); else n_pass++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_total++; if (bus.fwd_ready !== 1'b1) $display("FAIL post_rst_fwd_ready got %b want 1", bus.fwd_ready); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_slope_classes();
    logic signed [2*W-1:0] xs [7];
    logic signed [W-1:0]   go [7];
    logic                  gm [7];
    xs = '{18'sd5, -18'sd7, 18'sd1, -18'sd1, 18'sd0, 18'sd2, -18'sd2};
    go = '{9'sd10, -9'sd10, 9'sd0, 9'sd0, 9'sd0, 9'sd10, -9'sd10};
    gm = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, xs[i], 1'b0, '0, 1'b1);
    n_total++; if (bus.level !== 5'd7) $display("FAIL slope_level got %0d want 7", bus.level); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b1, 9'sd10, 1'b1);
      n_total++; if (bus.grad_valid !== 1'b1) $display("FAIL slope_valid[%0d] got %b want 1", i, bus.grad_valid); else n_pass++;
      n_total++; if (bus.grad_out !== go[i]) $display("FAIL slope_out[%0d] got %0d want %0d", i, bus.grad_out, go[i]); else n_pass++;
      n_total++; if (bus.grad_mask !== gm[i]) $display("FAIL slope_mask[%0d] got %b want %b", i, bus.grad_mask, gm[i]); else n_pass++;
    end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    n_total++; if (bus.grad_valid !== 1'b0) $display("FAIL slope_drain_valid got %b want 0", bus.grad_valid); else n_pass++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < D; i++) step(1'b1, rand_x(), 1'b0, '0, 1'b1);
    n_total++; if (bus.level !== 5'd16) $display("FAIL full_level got %0d want 16", bus.level); else n_pass++;
    step(1'b1, rand_x(), 1'b1, rand_d(), 1'b1);
    n_total++; if (o_fr !== 1'b0) $display("FAIL full_fwd_ready got %b want 0", o_fr); else n_pass++;
    n_total++; if (o_br !== 1'b1) $display("FAIL full_bwd_ready got %b want 1", o_br); else n_pass++;
    n_total++; if (bus.level !== 5'd15) $display("FAIL full_pop_level got %0d want 15", bus.level); else n_pass++;
    n_total++; if (bus.grad_out !== e_go) $display("FAIL full_pop_out got %0d want %0d", bus.grad_out, e_go); else n_pass++;
    step(1'b1, rand_x(), 1'b0, '0, 1'b1);
    n_total++; if (o_fr !== 1'b1) $display("FAIL refill_fwd_ready got %b want 1", o_fr); else n_pass++;
    n_total++; if (bus.level !== 5'd16) $display("FAIL refill_level got %0d want 16", bus.level); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, rand_d(), 1'b1);
      n_total++; if (bus.grad_out !== e_go) $display("FAIL drain8_out[%0d] got %0d want %0d", i, bus.grad_out, e_go); else n_pass++;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, rand_x(), 1'b1, rand_d(), 1'b1);
      n_total++; if (bus.level !== 5'd8) $display("FAIL wrap_level[%0d] got %0d want 8", i, bus.level); else n_pass++;
      n_total++; if (bus.grad_out !== e_go || bus.grad_mask !== e_gm)
        $display("FAIL wrap_grad[%0d] got %0d/%b want %0d/%b", i, bus.grad_out, bus.grad_mask, e_go, e_gm); else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, rand_d(), 1'b1);
      n_total++; if (bus.grad_out !== e_go) $display("FAIL wrap_drain[%0d] got %0d want %0d", i, bus.grad_out, e_go); else n_pass++;
    end
    n_total++; if (bus.level !== 5'd0) $display("FAIL wrap_end_level got %0d want 0", bus.level); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic signed [W-1:0] held;
    do_reset();
    step(1'b1, 18'sd40, 1'b0, '0, 1'b0);
    step(1'b1, -18'sd40, 1'b0, '0, 1'b0);
    step(1'b1, 18'sd3, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 9'sd77, 1'b0);
    n_total++; if (bus.grad_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", bus.grad_valid); else n_pass++;
    n_total++; if (bus.grad_out !== 9'sd77) $display("FAIL bp_first_out got %0d want 77", bus.grad_out); else n_pass++;
    held = bus.grad_out;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, 1'b1, 9'sd5, 1'b0);
      n_total++; if (o_br !== 1'b0) $display("FAIL bp_bwd_ready[%0d] got %b want 0", i, o_br); else n_pass++;
      n_total++; if (bus.grad_out !== held) $display("FAIL bp_hold[%0d] got %0d want %0d", i, bus.grad_out, held); else n_pass++;
      n_total++; if (bus.level !== 5'd2) $display("FAIL bp_level[%0d] got %0d want 2", i, bus.level); else n_pass++;
    end
    step(1'b0, '0, 1'b1, 9'sd6, 1'b1);
    n_total++; if (o_br !== 1'b1) $display("FAIL bp_release1 got %b want 1", o_br); else n_pass++;
    n_total++; if (bus.grad_out !== -9'sd6) $display("FAIL bp_second_out got %0d want -6", bus.grad_out); else n_pass++;
    step(1'b0, '0, 1'b1, 9'sd7, 1'b1);
    n_total++; if (o_br !== 1'b1) $display("FAIL bp_release2 got %b want 1", o_br); else n_pass++;
    n_total++; if (bus.grad_out !== 9'sd7) $display("FAIL bp_third_out got %0d want 7", bus.grad_out); else n_pass++;
    n_total++; if (bus.level !== 5'd0) $display("FAIL bp_end_level got %0d want 0", bus.level); else n_pass++;
  endtask

  task automatic test_empty();
    do_reset();
    step(1'b0, '0, 1'b1, 9'sd9, 1'b1);
    n_total++; if (o_br !== 1'b0) $display("FAIL empty_bwd_ready got %b want 0", o_br); else n_pass++;
    n_total++; if (bus.grad_valid !== 1'b0) $display("FAIL empty_valid got %b want 0", bus.grad_valid); else n_pass++;
    step(1'b1, -18'sd9, 1'b1, 9'sd9, 1'b1);
    n_total++; if (o_br !== 1'b0) $display("FAIL empty_push_cycle_ready got %b want 0", o_br); else n_pass++;
    n_total++; if (bus.grad_valid !== 1'b0) $display("FAIL empty_push_cycle_valid got %b want 0", bus.grad_valid); else n_pass++;
    step(1'b0, '0, 1'b1, 9'sd9, 1'b1);
    n_total++; if (o_br !== 1'b1) $display("FAIL empty_pop_ready got %b want 1", o_br); else n_pass++;
    n_total++; if (bus.grad_valid !== 1'b1 || bus.grad_out !== -9'sd9)
      $display("FAIL empty_out got %b/%0d want 1/-9", bus.grad_valid, bus.grad_out); else n_pass++;
  endtask

  task automatic test_saturation();
    logic signed [W-1:0] want;
`ifdef ACT_GRAD_SAT_EN
    want = 9'sd255;
`else
    want = -9'sd256;
`endif
    do_reset();
    step(1'b1, -18'sd300, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1, -9'sd256, 1'b1);
    n_total++; if (bus.grad_out !== want) $display("FAIL sat_out got %0d want %0d", bus.grad_out, want); else n_pass++;
    n_total++; if (bus.grad_mask !== 1'b1) $display("FAIL sat_mask got %b want 1", bus.grad_mask); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 18'sd100, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 9'sd1, 1'b0);
    n_total++; if (bus.level !== 5'd5 || bus.grad_valid !== 1'b1)
      $display("FAIL mid_pre got %0d/%b want 5/1", bus.level, bus.grad_valid); else n_pass++;
    do_reset();
    n_total++; if (bus.level !== 5'd0) $display("FAIL mid_level got %0d want 0", bus.level); else n_pass++;
    n_total++; if (bus.grad_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", bus.grad_valid); else n_pass++;
    n_total++; if (bus.grad_out !== 9'sd0) $display("FAIL mid_out got %0d want 0", bus.grad_out); else n_pass++;
    step(1'b1, -18'sd50, 1'b0, '0, 1'b1);
    step(1'b1, 18'sd0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1, 9'sd33, 1'b1);
    n_total++; if (bus.grad_out !== -9'sd33) $display("FAIL mid_fresh1 got %0d want -33", bus.grad_out); else n_pass++;
    step(1'b0, '0, 1'b1, 9'sd33, 1'b1);
    n_total++; if (bus.grad_out !== 9'sd0 || bus.grad_mask !== 1'b0)
      $display("FAIL mid_fresh2 got %0d/%b want 0/0", bus.grad_out, bus.grad_mask); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_x(), 1'($urandom_range(0, 1)), rand_d(),
           1'($urandom_range(0, 3) != 0));
      n_total++; if (o_fr !== e_fr || o_br !== e_br)
        $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i, o_fr, o_br, e_fr, e_br); else n_pass++;
      n_total++; if (bus.level !== 5'(q.size()))
        $display("FAIL rnd_level[%0d] got %0d want %0d", i, bus.level, q.size()); else n_pass++;
      n_total++; if (bus.grad_valid !== e_gv)
        $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.grad_valid, e_gv); else n_pass++;
      if (e_gv) begin
        n_total++; if (bus.grad_out !== e_go || bus.grad_mask !== e_gm)
          $display("FAIL rnd_grad[%0d] got %0d/%b want %0d/%b", i, bus.grad_out, bus.grad_mask, e_go, e_gm); else n_pass++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_slope_classes();
    test_full_wrap();
    test_backpressure();
    test_empty();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
